// File: rtl/btb_redirect_ctrl.sv
// btb_redirect_ctrl: carries BTB predictions down the IF/ID/EX pipe, detects
// mispredicts in EX, drives flush and PC redirect, and owns the BTB write port
// for both training updates and full-table invalidation sweeps.
module btb_redirect_ctrl #(
    parameter int IDX_BITS = 8,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                if_predicted,
    input  logic [XLEN-1:0]     if_pred_target,
    input  logic                ex_valid,
    input  logic [XLEN-1:0]     ex_pc,
    input  logic                ex_taken,
    input  logic [XLEN-1:0]     ex_target,
    input  logic                inval_req,
    output logic [1:0]          next_pc_sel,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                flush,
    output logic                inval_busy,
    output logic                upd_en,
    output logic                upd_clear,
    output logic [IDX_BITS-1:0] upd_idx,
    output logic [XLEN-1:0]     upd_pc,
    output logic [XLEN-1:0]     upd_target,
    output logic                upd_taken,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispredict_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};
    localparam logic [IDX_BITS-1:0] ONE_IDX  = {{(IDX_BITS-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [IDX_BITS-1:0] sweep_cnt, sweep_cnt_nxt;

    logic                id_pred, ex_pred;
    logic [XLEN-1:0]     id_tgt, ex_tgt;
    logic                mis;

    logic                tr_en, tr_taken;
    logic [XLEN-1:0]     tr_pc, tr_target;

    assign inval_busy = (state == SWEEP);
    assign mis   = ex_valid && ((ex_taken != ex_pred) || (ex_taken && (ex_target != ex_tgt)));
    assign flush = mis;

    // Fetch PC select and recovery address; a mispredict overrides any prediction.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        next_pc_sel = 2'b00;
        redirect_pc = '0;
        if (mis) begin
            next_pc_sel = 2'b10;
            redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
        end else if (if_predicted && !inval_busy && !stall) begin
            next_pc_sel = 2'b01;
        end
    end

    // Prediction pipe IF->ID->EX; flush clears it and wins over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pred <= 1'b0;
            id_tgt  <= '0;
            ex_pred <= 1'b0;
            ex_tgt  <= '0;
        end else if (mis) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            id_pred <= 1'b0;
            id_tgt  <= '0;
            ex_pred <= 1'b0;
            ex_tgt  <= '0;
        end else if (!stall) begin
            id_pred <= if_predicted && !inval_busy;
            id_tgt  <= if_pred_target;
            ex_pred <= id_pred;
            ex_tgt  <= id_tgt;
        end
    end

    // Sweep sequencer next state: one entry per cycle, back to IDLE after the last index.
    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        case (state)
            IDLE: begin
                if (inval_req) begin
                    state_nxt     = SWEEP;
                    sweep_cnt_nxt = '0;
                end
            end
            SWEEP: begin
                if (sweep_cnt == LAST_IDX) begin
                    state_nxt     = IDLE;
                    sweep_cnt_nxt = '0;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + ONE_IDX;
                end
            end
            default: begin
                state_nxt     = IDLE;
                sweep_cnt_nxt = '0;
            end
        endcase
    end

    // Sweep sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    // Training capture: one-cycle pulse per resolved branch, only when the sweep is not claiming the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_en     <= 1'b0;
            tr_taken  <= 1'b0;
            tr_pc     <= '0;
            tr_target <= '0;
        end else begin
            tr_en <= (state == IDLE) && ex_valid && !inval_req;
            if ((state == IDLE) && ex_valid && !inval_req) begin
                tr_taken  <= ex_taken;
                tr_pc     <= ex_pc;
                tr_target <= ex_target;
            end
        end
    end

    // BTB write port mux: sweep owns the port while busy, otherwise the training register drives it.
    always_comb begin
        upd_en     = tr_en;
        upd_clear  = 1'b0;
        upd_idx    = tr_pc[IDX_BITS+1:2];
        upd_pc     = tr_pc;
        upd_target = tr_target;
        upd_taken  = tr_taken;
        if (state == SWEEP) begin
            upd_en     = 1'b1;
            upd_clear  = 1'b1;
            upd_idx    = sweep_cnt;
            upd_pc     = '0;
            upd_target = '0;
            upd_taken  = 1'b0;
        end
    end

    // Performance counters; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (ex_valid) branch_cnt     <= branch_cnt + 32'd1;
            if (mis)      mispredict_cnt <= mispredict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_btb_redirect_ctrl.sv
// Self-checking bench for btb_redirect_ctrl: table-driven EX resolution
// vectors, hand-written stall / sweep / reset sequences, and a scoreboard
// queue for the one-cycle-late training updates.
module tb_btb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, if_predicted, ex_valid, ex_taken, inval_req;
    logic [31:0] if_pred_target, ex_pc, ex_target;
    logic [1:0]  next_pc_sel;
    logic [31:0] redirect_pc, upd_pc, upd_target, branch_cnt, mispredict_cnt;
    logic        flush, inval_busy, upd_en, upd_clear, upd_taken;
    logic [7:0]  upd_idx;

    int errors = 0;
    int checks = 0;
    int exp_branch = 0;
    int exp_mis = 0;
    bit sb_on = 1'b0;

    typedef struct {
        logic        pred;
        logic [31:0] ptgt;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        flush;
        logic [1:0]  sel;
        logic [31:0] redir;
    } vec_t;

    typedef struct {
        logic        en;
        logic [7:0]  idx;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } upd_t;

    upd_t sb_q[$];
    vec_t vecs[7];

    btb_redirect_ctrl #(.IDX_BITS(8), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .if_predicted(if_predicted), .if_pred_target(if_pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .inval_req(inval_req),
        .next_pc_sel(next_pc_sel), .redirect_pc(redirect_pc), .flush(flush),
        .inval_busy(inval_busy), .upd_en(upd_en), .upd_clear(upd_clear),
        .upd_idx(upd_idx), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; if_predicted = 0; if_pred_target = 0;
        ex_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; inval_req = 0;
    endtask

    task automatic check_redirect(input string tag, input logic f, input logic [1:0] s, input logic [31:0] r);
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, f});
        check({tag, ".sel"}, {30'b0, next_pc_sel}, {30'b0, s});
        check({tag, ".redirect_pc"}, redirect_pc, r);
    endtask

    task automatic check_counters(input string tag);
        check({tag, ".branch_cnt"}, branch_cnt, 32'(exp_branch));
        check({tag, ".mispredict_cnt"}, mispredict_cnt, 32'(exp_mis));
    endtask

    // Scoreboard producer: an EX resolution seen at an edge means a write is expected in the following cycle.
    always @(posedge clk) begin
        upd_t e;
        if (sb_on && rst_n) begin
            e.en    = ex_valid && !inval_req;
            e.idx   = ex_pc[9:2];
            e.pc    = ex_pc;
            e.tgt   = ex_target;
            e.taken = ex_taken;
            sb_q.push_back(e);
        end
    end

    // Scoreboard consumer: compare the BTB write port mid-cycle.
    always @(negedge clk) begin
        upd_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("upd_en", {31'b0, upd_en}, {31'b0, e.en});
            if (e.en) begin
                check("upd_clear", {31'b0, upd_clear}, 32'd0);
                check("upd_idx", {24'b0, upd_idx}, {24'b0, e.idx});
                check("upd_pc", upd_pc, e.pc);
                check("upd_target", upd_target, e.tgt);
                check("upd_taken", {31'b0, upd_taken}, {31'b0, e.taken});
            end
        end
    end

    // Runs one full invalidation sweep from IDLE; stops early (in the middle of cycle stop_at) if stop_at < 256.
    task automatic run_sweep(input int stop_at, input bit with_branch);
        inval_req = 1;
        if (with_branch) begin
            // Simultaneous resolution: counted, but its training write must be dropped.
            ex_valid = 1; ex_pc = 32'h0000_0A00; ex_taken = 0; ex_target = 0;
            exp_branch++;
        end
        step();
        inval_req = 0; ex_valid = 0; if_predicted = 1; if_pred_target = 32'h0000_0800;
        for (int k = 0; k < 256; k++) begin
            ex_valid = 0; inval_req = 0;
            if (k == 50) begin
                ex_valid = 1; ex_pc = 32'h0000_0600; ex_taken = 1; ex_target = 32'h0000_0900;
            end
            if (k == 100) inval_req = 1;
            @(negedge clk);
            check("sweep.busy", {31'b0, inval_busy}, 32'd1);
            check("sweep.upd_en", {31'b0, upd_en}, 32'd1);
            check("sweep.upd_clear", {31'b0, upd_clear}, 32'd1);
            check("sweep.upd_idx", {24'b0, upd_idx}, 32'(k));
            if (k == 50) begin
                check_redirect("sweep.mis", 1'b1, 2'b10, 32'h0000_0900);
                exp_branch++; exp_mis++;
            end else begin
                check("sweep.sel", {30'b0, next_pc_sel}, 32'd0);
            end
            if (k == stop_at) return;
            step();
        end
        ex_valid = 0; inval_req = 0;
        @(negedge clk);
        check("post_sweep.busy", {31'b0, inval_busy}, 32'd0);
        check("post_sweep.upd_en", {31'b0, upd_en}, 32'd0);
        check("post_sweep.sel", {30'b0, next_pc_sel}, 32'd1);
        check_counters("post_sweep");
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check("post_sweep.no_resweep", {31'b0, inval_busy | upd_en}, 32'd0);
        end
        if_predicted = 0; if_pred_target = 0;
        step(); step(); step();
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_1234, 1'b1, 32'h0000_0100, 1'b0, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0,         32'h0000_0040, 1'b1, 32'h0000_0200, 1'b1, 2'b10, 32'h0000_0200};
        vecs[2] = '{1'b1, 32'h0000_0200, 32'h0000_007C, 1'b0, 32'h0,         1'b1, 2'b10, 32'h0000_0080};
        vecs[3] = '{1'b1, 32'h0000_0300, 32'h0000_0088, 1'b1, 32'h0000_0304, 1'b1, 2'b10, 32'h0000_0304};
        vecs[4] = '{1'b0, 32'h0,         32'h0000_0050, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b1, 2'b10, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_ABC0, 32'h0000_03FC, 1'b1, 32'h0000_ABC0, 1'b0, 2'b00, 32'h0};

        idle_inputs();
        rst_n = 0;
        #12;
        check("rst.sel", {30'b0, next_pc_sel}, 32'd0);
        check("rst.flush", {31'b0, flush}, 32'd0);
        check("rst.busy", {31'b0, inval_busy}, 32'd0);
        check("rst.upd_en", {31'b0, upd_en}, 32'd0);
        check("rst.upd_idx", {24'b0, upd_idx}, 32'd0);
        check_counters("rst");
        @(posedge clk);
        #1;
        rst_n = 1;
        sb_on = 1;

        // Table-driven EX resolutions: load prediction, wait two edges, resolve.
        foreach (vecs[i]) begin
            if_predicted = vecs[i].pred; if_pred_target = vecs[i].ptgt;
            @(negedge clk);
            check($sformatf("vec%0d.fetch_sel", i), {30'b0, next_pc_sel}, vecs[i].pred ? 32'd1 : 32'd0);
            step();
            if_predicted = 0; if_pred_target = 0;
            step();
            ex_valid = 1; ex_pc = vecs[i].pc; ex_taken = vecs[i].taken; ex_target = vecs[i].tgt;
            @(negedge clk);
            check_redirect($sformatf("vec%0d", i), vecs[i].flush, vecs[i].sel, vecs[i].redir);
            exp_branch++;
            if (vecs[i].flush) exp_mis++;
            step();
            ex_valid = 0;
            @(negedge clk);
            check_counters($sformatf("vec%0d", i));
            step();
        end

        // Stall hold: prediction in EX must survive three stalled edges.
        if_predicted = 1; if_pred_target = 32'h0000_0500;
        step();
        if_predicted = 0; if_pred_target = 0;
        step();
        stall = 1; if_predicted = 1; if_pred_target = 32'h0000_0DEAD;
        @(negedge clk);
        check("stall.sel", {30'b0, next_pc_sel}, 32'd0);
        step(); step(); step();
        ex_valid = 1; ex_pc = 32'h0000_0020; ex_taken = 1; ex_target = 32'h0000_0500;
        @(negedge clk);
        check_redirect("stall.hold", 1'b0, 2'b00, 32'h0);
        exp_branch++;
        step();
        ex_valid = 0; stall = 0; if_predicted = 0; if_pred_target = 0;
        step(); step();

        // Mispredict during stall must still flush and clear both stages.
        if_predicted = 1; if_pred_target = 32'h0000_0B00;
        step(); step();
        stall = 1; if_predicted = 0; if_pred_target = 0;
        ex_valid = 1; ex_pc = 32'h0000_0010; ex_taken = 0; ex_target = 0;
        @(negedge clk);
        check_redirect("stall.mis", 1'b1, 2'b10, 32'h0000_0014);
        exp_branch++; exp_mis++;
        step();
        ex_valid = 0; stall = 0;
        step();
        ex_valid = 1; ex_pc = 32'h0000_0030; ex_taken = 1; ex_target = 32'h0000_0B00;
        @(negedge clk);
        check_redirect("flush.cleared", 1'b1, 2'b10, 32'h0000_0B00);
        exp_branch++; exp_mis++;
        step();
        ex_valid = 0;
        @(negedge clk);
        check_counters("stall");
        step();

        // Full sweep with a simultaneous branch, a mid-sweep mispredict and an ignored re-request.
        sb_on = 0;
        step(); step();
        run_sweep(256, 1'b1);

        // Second sweep interrupted by asynchronous reset at index 100.
        run_sweep(100, 1'b0);
        #1;
        rst_n = 0;
        #1;
        check("arst.busy", {31'b0, inval_busy}, 32'd0);
        check("arst.upd_en", {31'b0, upd_en}, 32'd0);
        exp_branch = 0; exp_mis = 0;
        check_counters("arst");
        idle_inputs();
        step();
        rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("arst.no_write", {31'b0, upd_en | inval_busy}, 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_redirect_ctrl.md
Name: btb_redirect_ctrl

Overview:
Controller that sits between the branch target buffer, the fetch PC mux and the EX-stage branch resolution logic.
- Carries each fetch-time prediction down the IF/ID/EX pipe alongside its instruction.
- Compares that prediction against the EX outcome and drives flush and PC redirect.
- Sequences all BTB write traffic: training updates, plus a full-table invalidation sweep on request (fence.i / context change).

Parameters:
IDX_BITS, 8, BTB index width; table holds 2^IDX_BITS entries, index = pc[IDX_BITS+1:2]
XLEN, 32, address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; freezes IF/ID and ID/EX prediction registers
if_predicted  in  1  BTB hit-and-predict-taken for current fetch PC
if_pred_target  in  XLEN  BTB predicted target
ex_valid  in  1  control-flow instruction resolved in EX this cycle
ex_pc  in  XLEN  PC of resolving instruction
ex_taken  in  1  actual direction
ex_target  in  XLEN  actual target
inval_req  in  1  request full BTB invalidation (single-cycle pulse)
next_pc_sel  out  2  00 pc+4, 01 BTB target, 10 redirect_pc
redirect_pc  out  XLEN  recovery PC
flush  out  1  kill IF/ID and ID/EX contents
inval_busy  out  1  sweep in progress
upd_en  out  1  BTB write strobe
upd_clear  out  1  write is an invalidation (valid:=0)
upd_idx  out  IDX_BITS  BTB entry index
upd_pc  out  XLEN  tag PC
upd_target  out  XLEN  target
upd_taken  out  1  training direction
branch_cnt  out  32  resolved control-flow count
mispredict_cnt  out  32  mispredict count

Behaviour:
- Reset (rst_n=0, async): FSM=IDLE, all prediction pipe registers 0, all outputs 0, sweep counter 0, both perf counters 0.
- Prediction pipe:
  - id_pred/id_tgt <= if_predicted&&!inval_busy / if_pred_target; ex_pred/ex_tgt <= id_pred/id_tgt.
  - Both stages hold on stall.
  - flush has priority over stall: on flush, both stages are cleared to 0 on the next edge.
- Mispredict (combinational, same cycle as ex_valid): mis = ex_valid && (ex_taken != ex_pred || (ex_taken && ex_target != ex_tgt)).
- mis=1:
  - flush=1, next_pc_sel=10.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4 (XLEN wrap).
- Otherwise:
  - next_pc_sel=01 if if_predicted && !inval_busy && !stall; else 00.
  - redirect_pc=0.
- Counters: branch_cnt += 1 on every ex_valid; mispredict_cnt += 1 on mis. Both wrap at 2^32 and saturate never.
- Training update: registered, 1-cycle latency.
  - The cycle after an ex_valid in IDLE: upd_en=1, upd_clear=0, upd_idx=ex_pc[IDX_BITS+1:2], upd_pc=ex_pc, upd_target=ex_target, upd_taken=ex_taken.
  - Update is issued for every resolved branch, correct or not (BTB updates its counter).
- FSM states:
  - IDLE: inval_req -> SWEEP next edge with counter=0.
  - SWEEP: each cycle upd_en=1, upd_clear=1, upd_idx=counter, upd_pc/upd_target/upd_taken=0, counter+1; at counter=2^IDX_BITS-1, write the last entry, then go to IDLE.
  - Sweep length is exactly 2^IDX_BITS cycles with inval_busy=1 throughout.
- During SWEEP:
  - Training updates are dropped; sweep owns the write port.
  - Predictions are suppressed (next_pc_sel never 01).
  - Mispredict flush/redirect still operates.
  - inval_req is ignored.
- Simultaneous ex_valid and inval_req in IDLE: the training update is dropped; the sweep starts next edge.
- Reset mid-sweep: immediate return to IDLE; counter=0, upd_en=0.
- upd_en is never asserted in two consecutive cycles for the same training event.

Test Plan:
- Correct prediction: if_predicted=1, target 0x100; after 2 unstalled edges ex_valid=1, ex_taken=1, ex_target=0x100 -> flush=0; next cycle upd_en=1, upd_taken=1, upd_idx=ex_pc[9:2]; branch_cnt=1, mispredict_cnt=0.
- Not-predicted taken: ex_pred=0, ex_valid=1, ex_pc=0x40, ex_taken=1, ex_target=0x200 -> same cycle flush=1, next_pc_sel=10, redirect_pc=0x200; mispredict_cnt=1; following edge id/ex pred regs=0.
- Predicted taken, actually not taken: ex_pred=1, ex_pc=0x7C, ex_taken=0 -> redirect_pc=0x80, flush=1. Wrong target variant: ex_tgt=0x300, ex_target=0x304, taken -> redirect_pc=0x304.
- Stall hold: predicted entry in ID, stall=1 for 3 cycles -> ex_pred unchanged for the 3 cycles; a mispredict during the stall still flushes and clears the regs.
- Sweep (IDX_BITS=8): pulse inval_req -> next 256 cycles upd_en=1, upd_clear=1, upd_idx 0..255, inval_busy=1; next_pc_sel never 01 despite if_predicted=1; ex_valid mid-sweep produces no training write; IDLE after cycle 256.
- Async reset at sweep index 100: rst_n low between edges -> inval_busy, upd_en, and both counters 0 immediately; after release no writes until a new inval_req.
